// File: rtl/uart_rx_mem_if.sv
// Data-bus port bundle shared by the memory-mapped UART receiver and the CPU.
// The CPU side drives strobes, address and write data; the peripheral
// returns registered read data.
interface uart_rx_mem_if;
    logic [3:0]  writeb;
    logic        read;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output writeb, read, addr, wdata, input rdata);
    modport slave  (input writeb, read, addr, wdata, output rdata);
endinterface

// File: rtl/uart_rx_mem.sv
// Memory-mapped UART receiver: deserialises frames from rx into a byte FIFO
// and exposes DATA (0), STATUS (1) and COUNT (2) word registers on the bus.
// Optional feature macro UART_RX_PARITY_EN: when defined, frames are 8E1 and
// parity errors set the sticky PERR flag; otherwise frames are 8N1.
module uart_rx_mem #(
    parameter int CLKS_PER_BIT = 625,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    uart_rx_mem_if.slave bus,
    output logic         irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]         HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]         BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]         CLK_ONE   = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t                state;
    logic                  rx_meta;
    logic                  rxs;
    logic [CW-1:0]         clk_cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  ovr;
    logic                  ferr;
    logic                  perr;
    logic                  empty;
    logic                  full;
    logic                  half_done;
    logic                  bit_done;
    logic                  stop_done;
    logic                  push_req;
    logic                  do_push;
    logic                  do_pop;
    logic                  status_wr;
    logic                  unused_bits;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign half_done = (clk_cnt == HALF_LAST);
    assign bit_done  = (clk_cnt == BIT_LAST);
    assign stop_done = (state == STOP) && bit_done;
    assign do_push   = push_req && !full;
    assign do_pop    = bus.read && (bus.addr == 8'd0) && !empty;
    assign status_wr = (|bus.writeb) && (bus.addr == 8'd1);
    assign unused_bits = ^{bus.wdata[31:5], bus.wdata[1:0]};

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    assign push_req = stop_done && rxs && !par_bad;
`else
    assign push_req = stop_done && rxs;
    assign perr     = 1'b0;
`endif

    // Two-flop synchroniser on the asynchronous serial input, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Frame receiver: counters restart on every state change, bits sampled mid-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (!rxs) state <= START;
                end
                START: begin
                    if (half_done) begin
                        clk_cnt <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CLK_ONE;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CLK_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        par_bad <= ^{shreg, rxs};
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CLK_ONE;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        state   <= rxs ? IDLE : WAIT_HIGH;
                    end else begin
                        clk_cnt <= clk_cnt + CLK_ONE;
                    end
                end
                WAIT_HIGH: begin
                    clk_cnt <= '0;
                    if (rxs) state <= IDLE;
                end
                default: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags: write-1-to-clear, with a same-cycle set taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr <= 1'b0;
`endif
        end else begin
            if (status_wr && bus.wdata[2]) ovr  <= 1'b0;
            if (push_req && full)          ovr  <= 1'b1;
            if (status_wr && bus.wdata[3]) ferr <= 1'b0;
            if (stop_done && !rxs)         ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
            if (status_wr && bus.wdata[4]) perr <= 1'b0;
            if ((state == PARITY) && bit_done && (^{shreg, rxs})) perr <= 1'b1;
`endif
        end
    end

    // Registered read data; holds its value on cycles without a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rdata <= '0;
        end else if (bus.read) begin
            case (bus.addr)
                8'd0:    bus.rdata <= empty ? 32'hffff_ffff : {24'd0, mem[rd_ptr]};
                8'd1:    bus.rdata <= {27'd0, perr, ferr, ovr, full, !empty};
                8'd2:    bus.rdata <= {{(31 - DEPTH_LOG2){1'b0}}, count};
                default: bus.rdata <= '0;
            endcase
        end
    end

    // Interrupt request, registered from the state as of the previous edge.
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= !empty || ovr || ferr || perr;
    end
endmodule

// File: tb/tb_uart_rx_mem.sv
// Self-checking bench for uart_rx_mem (default 8N1 build, CLKS_PER_BIT = 16).
// A queue-based model of the FIFO and sticky flags predicts every bus read and
// the irq line; directed steps also pin literal expected values.
module tb_uart_rx_mem;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic irq;

    uart_rx_mem_if bus();

    uart_rx_mem #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus),
        .irq (irq)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mq[$];
    bit          m_ovr  = 1'b0;
    bit          m_ferr = 1'b0;

    bit          rd_check       = 1'b0;
    logic [31:0] rd_exp         = '0;
    string       rd_name        = "";
    bit          irq_check      = 1'b0;
    bit          irq_prev_valid = 1'b0;
    bit          irq_prev_model = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [7:0] a);
        case (a)
            8'd0:    return (mq.size() != 0) ? {24'd0, mq[0]} : 32'hffff_ffff;
            8'd1:    return {27'd0, 1'b0, m_ferr, m_ovr, (mq.size() == 16), (mq.size() != 0)};
            8'd2:    return 32'(mq.size());
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit modelIrq();
        return (mq.size() != 0) || m_ovr || m_ferr;
    endfunction

    // Compare process: read data one cycle after each read, irq one cycle behind the model.
    always @(negedge clk) begin
        if (rd_check) begin
            checkOutput(rd_name, bus.rdata, rd_exp);
            rd_check = 1'b0;
        end
        if (irq_check && irq_prev_valid)
            checkOutput("model irq", {31'd0, irq}, {31'd0, irq_prev_model});
        irq_prev_valid = irq_check;
        irq_prev_model = modelIrq();
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Generic bus cycle; reads arm the model comparison, writes update the model flags.
    task automatic applyStimulus(input bit is_write, input logic [7:0] a, input logic [31:0] d, input string name);
        bus.addr = a;
        if (is_write) begin
            bus.writeb = 4'hf;
            bus.wdata  = d;
            @(posedge clk); #2;
            bus.writeb = 4'h0;
            if (a == 8'd1) begin
                if (d[2]) m_ovr  = 1'b0;
                if (d[3]) m_ferr = 1'b0;
            end
        end else begin
            bus.read = 1'b1;
            rd_exp   = modelRead(a);
            @(posedge clk); #2;
            bus.read = 1'b0;
            if (a == 8'd0 && mq.size() != 0) void'(mq.pop_front());
            rd_name  = {"model ", name};
            rd_check = 1'b1;
        end
    endtask

    task automatic readLit(input logic [7:0] a, input string name, input logic [31:0] lit);
        applyStimulus(1'b0, a, 32'd0, name);
        @(negedge clk);
        checkOutput(name, bus.rdata, lit);
        @(posedge clk); #2;
    endtask

    task automatic sendFrame(input logic [7:0] b, input bit stop_lvl, input bit upd_model);
        irq_check = 1'b0;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop_lvl;
        idle(CPB);
        if (upd_model) begin
            if (!stop_lvl)              m_ferr = 1'b1;
            else if (mq.size() == 16)   m_ovr  = 1'b1;
            else                        mq.push_back(b);
        end
        irq_check = 1'b1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        rst        = 1'b1;
        rx         = 1'b1;
        bus.writeb = 4'h0;
        bus.read   = 1'b0;
        bus.addr   = 8'd0;
        bus.wdata  = 32'd0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset rdata", bus.rdata, 32'd0);
        checkOutput("reset irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #2;
        irq_check = 1'b1;

        // Empty FIFO reads, unmapped address, ignored DATA write.
        readLit(8'd0, "t2 empty data", 32'hffff_ffff);
        readLit(8'd1, "t2 status", 32'd0);
        readLit(8'd2, "t2 count", 32'd0);
        readLit(8'd3, "t2 unmapped", 32'd0);
        applyStimulus(1'b1, 8'd0, 32'h0000_0055, "t2 data write");
        readLit(8'd2, "t2 count after data write", 32'd0);

        // Single byte, pop, irq falls one cycle after the pop.
        sendFrame(8'ha5, 1'b1, 1'b1);
        idle(2);
        readLit(8'd2, "t1 count before", 32'd1);
        applyStimulus(1'b0, 8'd0, 32'd0, "t1 data");
        @(negedge clk);
        checkOutput("t1 data", bus.rdata, 32'h0000_00a5);
        checkOutput("t1 irq at pop", {31'd0, irq}, 32'd1);
        @(negedge clk);
        checkOutput("t1 irq after pop", {31'd0, irq}, 32'd0);
        @(posedge clk); #2;
        readLit(8'd2, "t1 count after", 32'd0);

        // Overflow: 17 bytes, 16 kept in order, OVR cleared by write-1.
        for (int i = 0; i < 17; i++) sendFrame(8'(i), 1'b1, 1'b1);
        idle(2);
        readLit(8'd2, "t3 count full", 32'd16);
        readLit(8'd1, "t3 status full", 32'h7);
        for (int i = 0; i < 16; i++) readLit(8'd0, "t3 data", 32'(i));
        readLit(8'd1, "t3 status ovr only", 32'h4);
        applyStimulus(1'b1, 8'd1, 32'h4, "t3 clear ovr");
        readLit(8'd1, "t3 status cleared", 32'd0);

        // Framing error followed by a long break, then a good frame.
        sendFrame(8'h3c, 1'b0, 1'b1);
        idle(40);
        rx = 1'b1;
        idle(4);
        readLit(8'd1, "t4 status ferr", 32'h8);
        readLit(8'd2, "t4 count", 32'd0);
        applyStimulus(1'b1, 8'd1, 32'h8, "t4 clear ferr");
        sendFrame(8'h81, 1'b1, 1'b1);
        idle(2);
        readLit(8'd0, "t4 next frame", 32'h0000_0081);

        // Short glitch on rx: no push, no flags.
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(30);
        readLit(8'd1, "t5 status", 32'd0);
        readLit(8'd2, "t5 count", 32'd0);

        // Pop on the same edge the stop bit completes: push and pop both land.
        sendFrame(8'h11, 1'b1, 1'b1);
        idle(2);
        fork
            sendFrame(8'h22, 1'b1, 1'b0);
            begin
                idle(154);
                applyStimulus(1'b0, 8'd0, 32'd0, "t6 data");
                mq.push_back(8'h22);
                @(negedge clk);
                checkOutput("t6 old head", bus.rdata, 32'h0000_0011);
                @(posedge clk); #2;
                readLit(8'd2, "t6 count", 32'd1);
            end
        join
        idle(2);
        readLit(8'd0, "t6 new byte", 32'h0000_0022);

        // Reset mid-frame with a byte already buffered.
        sendFrame(8'h5a, 1'b1, 1'b1);
        idle(2);
        readLit(8'd1, "t6 status before reset", 32'h1);
        irq_check = 1'b0;
        rx = 1'b0;
        idle(3 * CPB);
        rst = 1'b1;
        rx  = 1'b1;
        idle(2);
        rst = 1'b0;
        mq.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        @(negedge clk);
        checkOutput("t6 reset rdata", bus.rdata, 32'd0);
        checkOutput("t6 reset irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #2;
        irq_check = 1'b1;
        idle(12 * CPB);
        readLit(8'd2, "t6 reset count", 32'd0);
        readLit(8'd1, "t6 reset status", 32'd0);
        readLit(8'd0, "t6 reset data", 32'hffff_ffff);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_mem.md
Name: uart_rx_mem

Overview:
Memory-mapped UART receiver peripheral on the CPU data bus, sitting in the 1 KiB window at dmem_addr[31:10] == 3 beside the transmit UART. It deserialises 8N1 frames from the rx pin, buffers received bytes in a FIFO, and exposes data, status and count registers to the CPU. It uses the same bus signalling as the other data-bus peripherals (writeb, read, word addr, wdata, rdata).

Parameters:
CLKS_PER_BIT, 625, clk cycles per bit period; must be >= 4.
DEPTH_LOG2, 4, log2 of FIFO depth; default depth is 16 bytes.

Ports:
clk  input  1  single clock for the receiver and the bus; the CPU clock in the SoC.
rst  input  1  synchronous, active-high reset.
rx  input  1  asynchronous serial input; idles high.
writeb  input  4  byte write strobes, pre-gated by the SoC address decode.
read  input  1  read strobe, pre-gated by the SoC address decode.
addr  input  8  word address, taken from dmem_addr[9:2].
wdata  input  32  write data.
rdata  output  32  registered read data.
irq  output  1  high while the FIFO is non-empty or any sticky error bit is set.

Behaviour:
- Synchronisation: rx passes through a 2-FF synchroniser; both flops reset to 1. All logic below uses the synchronised value rxs.
- Reset: FSM to IDLE; FIFO empty (wr_ptr = rd_ptr = 0, count = 0); sticky flags cleared; rdata = 0; irq = 0. A reset during a frame abandons that frame and pushes nothing.
- The bit counter and the clock counter are cleared on every FSM state change.
- FSM states and transitions:
  - IDLE: when rxs == 0, go to START.
  - START: wait CLKS_PER_BIT/2 clocks, then sample rxs. If rxs == 0, go to DATA. If rxs == 1, treat it as a glitch and return to IDLE; no flags are set.
  - DATA: sample every CLKS_PER_BIT clocks, 8 samples in total, shifted in LSB first. Go to STOP after the 8th sample.
  - STOP: after CLKS_PER_BIT clocks, sample rxs.
    - If rxs == 1: push the byte and go to IDLE.
    - If rxs == 0: set FERR, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs == 1, then go to IDLE. This state also covers a break condition.
- FIFO:
  - Depth is 2^DEPTH_LOG2. Pointers are DEPTH_LOG2 bits wide and wrap naturally. Count is DEPTH_LOG2+1 bits.
  - A push while full drops the byte and sets OVR; the FIFO contents are unchanged.
  - A push and a pop in the same cycle both take effect; count is unchanged.
  - Empty-and-push-and-pop in the same cycle: the pop is ignored and the push proceeds.
- Register map (word addresses):
  - 0 DATA, read-only:
    - rdata = {24'd0, head byte} when non-empty; the pop occurs on the same edge.
    - rdata = 32'hffffffff when empty; no pop.
    - Writes are ignored.
  - 1 STATUS:
    - Read bits: [0] non-empty, [1] full, [2] OVR, [3] FERR, [4] PERR; all other bits 0.
    - Write (any writeb asserted): wdata bits 2/3/4 are write-1-to-clear for the corresponding flags.
    - If a set and a clear hit the same cycle, the set wins.
  - 2 COUNT, read-only: rdata = zero-extended count.
  - Other addresses: read returns 0; writes are ignored.
- Read latency: rdata updates on the clk edge at which read is high, which is 1 cycle of latency. rdata holds its value when read is low.
- irq is registered: it equals (count != 0) | OVR | FERR | PERR as of the previous edge.

Optional Feature:
UART_RX_PARITY_EN
- Defined: frame is 8E1. After DATA, a PARITY state samples one more bit at CLKS_PER_BIT. If XOR(data, parity) != 0, PERR is set and the byte is discarded; the FSM still proceeds to STOP. A stop-bit error in the same frame also sets FERR.
- Undefined: frame is 8N1, there is no PARITY state, and STATUS[4] reads as 0.

Test Plan:
1. CLKS_PER_BIT = 16. Send 8'hA5, then read addr 0 -> rdata = 32'h000000a5, COUNT goes 1 -> 0, and irq falls one cycle after the pop.
2. Read addr 0 with the FIFO empty after reset -> rdata = 32'hffffffff; STATUS = 0; COUNT = 0.
3. Send 17 bytes 8'h00..8'h10 with no reads -> COUNT = 16, STATUS = 32'h7 (non-empty, full, OVR). Then 16 reads return 8'h00..8'h0f in order; 8'h10 is lost. Write STATUS with wdata = 32'h4 -> OVR clears.
4. Drive a frame of 8'h3c with the stop bit held low, then hold rx low for 40 clocks, then release -> FERR set, COUNT = 0. The next good frame 8'h81 is received correctly.
5. Pulse rx low for 5 clocks (less than CLKS_PER_BIT/2 = 8) -> FSM returns to IDLE, no push, no flags set.
6. Assert read at addr 0 on the same clk edge that a stop bit completes, with COUNT = 1 -> old head returned, new byte pushed, COUNT stays 1. Assert rst mid-frame -> COUNT = 0, rdata = 0, irq = 0, and nothing from that frame is pushed.
